// File: rtl/light_phase_scheduler.sv
// Intersection phase scheduler: tick prescaler, phase FSM, request latches and registered lamp drive.
// Define PREEMPT_EN to add the emergency main-road preemption input.
//
// state  | meaning
// MAIN_G | main road green, side red; holds past MAIN_MIN until a request is pending
// MAIN_Y | main road yellow; picks SIDE_G, WALK or MAIN_G at exit
// SIDE_G | side road green; one SIDE_TIME extension while sensor stays high
// SIDE_Y | side road yellow, then back to MAIN_G
// WALK   | both roads red, pedestrian walk lamp on
module light_phase_scheduler #(
   parameter int TICK_DIV  = 25000000,
   parameter int MAIN_MIN  = 10,
   parameter int SIDE_TIME = 5,
   parameter int WALK_TIME = 6,
   parameter int YEL_TIME  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor,
   input  logic       walk_button,
`ifdef PREEMPT_EN
   input  logic       preempt,
`endif
   output logic       main_green,
   output logic       main_yellow,
   output logic       main_red,
   output logic       side_green,
   output logic       side_yellow,
   output logic       side_red,
   output logic       walk_light,
   output logic       tick,
   output logic [2:0] phase
);

   localparam int T_A   = (MAIN_MIN > SIDE_TIME) ? MAIN_MIN : SIDE_TIME;
   localparam int T_B   = (WALK_TIME > YEL_TIME) ? WALK_TIME : YEL_TIME;
   localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
   localparam int TW    = $clog2(T_MAX + 1);
   localparam int CW    = $clog2(TICK_DIV);

   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(TICK_DIV - 2);
   localparam logic [TW-1:0] T_MAIN   = TW'(MAIN_MIN);
   localparam logic [TW-1:0] T_SIDE   = TW'(SIDE_TIME);
   localparam logic [TW-1:0] T_WALK   = TW'(WALK_TIME);
   localparam logic [TW-1:0] T_YEL    = TW'(YEL_TIME);
   localparam logic [TW-1:0] T_ONE    = TW'(1);

   // lamp vector order: main g/y/r, side g/y/r, walk
   localparam logic [6:0] LAMPS_RST = 7'b100_001_0;

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      SIDE_G = 3'd2,
      SIDE_Y = 3'd3,
      WALK   = 3'd4
   } state_t;

   state_t        state, state_d;
   logic [TW-1:0] timer, timer_d;
   logic [CW-1:0] cnt;
   logic          ext_used, ext_d;
   logic          last_walk, last_d;
   logic          side_req, walk_req;
   logic          enter_side, enter_walk;
   logic          expire;
   logic          pre;
   logic [6:0]    lamps_d;

`ifdef PREEMPT_EN
   assign pre = preempt;
`else
   assign pre = 1'b0;
`endif

   // tick is registered one count early so it is high exactly while cnt == TICK_DIV-1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         tick <= (cnt == CNT_PRE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= MAIN_G;
         timer     <= T_MAIN;
         ext_used  <= 1'b0;
         last_walk <= 1'b1;
         side_req  <= 1'b0;
         walk_req  <= 1'b0;
         {main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk_light} <= LAMPS_RST;
      end else begin
         state     <= state_d;
         timer     <= timer_d;
         ext_used  <= ext_d;
         last_walk <= last_d;
         side_req  <= sensor | (side_req & ~enter_side);
         walk_req  <= walk_button | (walk_req & ~enter_walk);
         {main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk_light} <= lamps_d;
      end
   end

   always_comb begin
      state_d = state;
      timer_d = timer;
      ext_d   = ext_used;
      last_d  = last_walk;
      expire  = tick && (timer == T_ONE);
      case (state)
         MAIN_G: begin
            // past the minimum the timer parks at 1 until a request shows up
            if (tick && (timer != T_ONE)) begin
               timer_d = timer - 1'b1;
            end else if (expire && (side_req || walk_req) && !pre) begin
               state_d = MAIN_Y;
               timer_d = T_YEL;
            end
         end
         MAIN_Y: begin
            if (expire) begin
               if (pre || !(side_req || walk_req)) begin
                  state_d = MAIN_G;
                  timer_d = T_MAIN;
               end else if (side_req && (!walk_req || last_walk)) begin
                  state_d = SIDE_G;
                  timer_d = T_SIDE;
                  ext_d   = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  state_d = WALK;
                  timer_d = T_WALK;
                  last_d  = 1'b1;
               end
            end else if (tick) begin
               timer_d = timer - 1'b1;
            end
         end
         SIDE_G: begin
            if (pre) begin
               state_d = SIDE_Y;
               timer_d = T_YEL;
            end else if (expire) begin
               if (sensor && !ext_used) begin
                  timer_d = T_SIDE;
                  ext_d   = 1'b1;
               end else begin
                  state_d = SIDE_Y;
                  timer_d = T_YEL;
               end
            end else if (tick) begin
               timer_d = timer - 1'b1;
            end
         end
         SIDE_Y: begin
            if (expire) begin
               state_d = MAIN_G;
               timer_d = T_MAIN;
            end else if (tick) begin
               timer_d = timer - 1'b1;
            end
         end
         WALK: begin
            if (pre || expire) begin
               state_d = MAIN_G;
               timer_d = T_MAIN;
            end else if (tick) begin
               timer_d = timer - 1'b1;
            end
         end
         default: begin
            state_d = MAIN_G;
            timer_d = T_MAIN;
         end
      endcase

      enter_side = (state_d == SIDE_G) && (state != SIDE_G);
      enter_walk = (state_d == WALK) && (state != WALK);

      // lamps follow the next state so they change on the same edge as the phase
      case (state_d)
         MAIN_G:  lamps_d = 7'b100_001_0;
         MAIN_Y:  lamps_d = 7'b010_001_0;
         SIDE_G:  lamps_d = 7'b001_100_0;
         SIDE_Y:  lamps_d = 7'b001_010_0;
         WALK:    lamps_d = 7'b001_001_1;
         default: lamps_d = LAMPS_RST;
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_light_phase_scheduler.sv
// Bench for light_phase_scheduler: table-driven phase checks, hand sequences, and randomized
// requests against a tick/duration reference model. Preemption scenarios run when PREEMPT_EN is defined.
module tb_light_phase_scheduler;

   localparam int TD = 4;
   localparam int MM = 3;
   localparam int ST = 2;
   localparam int WT = 3;
   localparam int YT = 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sensor = 1'b0;
   logic walk_button = 1'b0;
`ifdef PREEMPT_EN
   logic preempt = 1'b0;
`endif
   logic main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk_light, tick;
   logic [2:0] phase;
   logic [6:0] dut_lamps;

   assign dut_lamps = {main_green, main_yellow, main_red, side_green, side_yellow, side_red, walk_light};

   light_phase_scheduler #(
      .TICK_DIV(TD), .MAIN_MIN(MM), .SIDE_TIME(ST), .WALK_TIME(WT), .YEL_TIME(YT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sensor(sensor),
      .walk_button(walk_button),
`ifdef PREEMPT_EN
      .preempt(preempt),
`endif
      .main_green(main_green),
      .main_yellow(main_yellow),
      .main_red(main_red),
      .side_green(side_green),
      .side_yellow(side_yellow),
      .side_red(side_red),
      .walk_light(walk_light),
      .tick(tick),
      .phase(phase)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // reference model: phase number, ticks elapsed in the phase, pending requests
   int m_cnt, m_ph, m_el;
   bit m_tick, m_ext, m_sreq, m_wreq, m_last_walk;

   typedef struct {
      int         edge_n;
      logic       s;
      logic       w;
      logic [2:0] ph;
   } vec_t;

   vec_t tbl [0:19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] lamps_for(input int ph);
      case (ph)
         0:       return 7'b1000010;
         1:       return 7'b0100010;
         2:       return 7'b0011000;
         3:       return 7'b0010100;
         4:       return 7'b0010011;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_ph = 0; m_el = 0; m_tick = 0;
      m_ext = 0; m_sreq = 0; m_wreq = 0; m_last_walk = 1;
   endtask

   task automatic model_step(input logic s, input logic w, input logic p);
      int nph, el1;
      bit enter;
      nph = m_ph; enter = 0; el1 = m_el + 1;
      case (m_ph)
         0: if (m_tick) begin
               if (el1 >= MM && (m_sreq || m_wreq) && !p) begin nph = 1; enter = 1; end
               else m_el = (el1 > MM) ? MM : el1;
            end
         1: if (m_tick) begin
               if (el1 >= YT) begin
                  enter = 1;
                  if (p || !(m_sreq || m_wreq)) nph = 0;
                  else if (m_sreq && m_wreq) nph = m_last_walk ? 2 : 4;
                  else nph = m_sreq ? 2 : 4;
               end else m_el = el1;
            end
         2: if (p) begin nph = 3; enter = 1; end
            else if (m_tick) begin
               if (el1 >= ST * (m_ext ? 2 : 1)) begin
                  if (s && !m_ext) begin m_ext = 1; m_el = el1; end
                  else begin nph = 3; enter = 1; end
               end else m_el = el1;
            end
         3: if (m_tick) begin
               if (el1 >= YT) begin nph = 0; enter = 1; end
               else m_el = el1;
            end
         4: if (p) begin nph = 0; enter = 1; end
            else if (m_tick) begin
               if (el1 >= WT) begin nph = 0; enter = 1; end
               else m_el = el1;
            end
         default: ;
      endcase
      if (enter) begin
         m_el = 0;
         if (nph == 2) begin m_ext = 0; m_last_walk = 0; end
         if (nph == 4) m_last_walk = 1;
      end
      m_sreq = s || (m_sreq && !(enter && nph == 2));
      m_wreq = w || (m_wreq && !(enter && nph == 4));
      m_ph = nph;
      m_cnt = (m_cnt + 1) % TD;
      m_tick = (m_cnt == TD - 1);
   endtask

   // one clock: advance the model with the inputs the DUT samples, then compare
   task automatic cyc();
      logic p;
      p = 1'b0;
`ifdef PREEMPT_EN
      p = preempt;
`endif
      @(posedge clk);
      model_step(sensor, walk_button, p);
      #1;
      check("model", {21'd0, phase, dut_lamps, tick}, {21'd0, 3'(m_ph), lamps_for(m_ph), m_tick});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sensor = 1'b0;
      walk_button = 1'b0;
`ifdef PREEMPT_EN
      preempt = 1'b0;
`endif
      #2;
      check("reset_async", {21'd0, phase, dut_lamps, tick}, {21'd0, 3'd0, 7'b1000010, 1'b0});
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int k, sg, bad, n;

      // single sensor pulse, then simultaneous sensor+walk (side first, then walk)
      tbl[0]  = '{0,  1'b0, 1'b0, 3'd0};
      tbl[1]  = '{1,  1'b1, 1'b0, 3'd0};
      tbl[2]  = '{11, 1'b0, 1'b0, 3'd0};
      tbl[3]  = '{12, 1'b0, 1'b0, 3'd1};
      tbl[4]  = '{15, 1'b0, 1'b0, 3'd1};
      tbl[5]  = '{16, 1'b0, 1'b0, 3'd2};
      tbl[6]  = '{23, 1'b0, 1'b0, 3'd2};
      tbl[7]  = '{24, 1'b0, 1'b0, 3'd3};
      tbl[8]  = '{27, 1'b0, 1'b0, 3'd3};
      tbl[9]  = '{28, 1'b0, 1'b0, 3'd0};
      tbl[10] = '{0,  1'b0, 1'b0, 3'd0};
      tbl[11] = '{1,  1'b1, 1'b1, 3'd0};
      tbl[12] = '{16, 1'b0, 1'b0, 3'd2};
      tbl[13] = '{28, 1'b0, 1'b0, 3'd0};
      tbl[14] = '{39, 1'b0, 1'b0, 3'd0};
      tbl[15] = '{40, 1'b0, 1'b0, 3'd1};
      tbl[16] = '{43, 1'b0, 1'b0, 3'd1};
      tbl[17] = '{44, 1'b0, 1'b0, 3'd4};
      tbl[18] = '{55, 1'b0, 1'b0, 3'd4};
      tbl[19] = '{56, 1'b0, 1'b0, 3'd0};

      #1;
      do_reset();

      // idle: main green throughout, tick every TD cycles
      for (int i = 1; i <= 200; i++) begin
         cyc();
         check("idle", {26'd0, phase, main_green, side_red, tick},
               {26'd0, 3'd0, 1'b1, 1'b1, (i % TD == TD - 1)});
      end

      k = 0;
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].edge_n == 0) begin
            do_reset();
            k = 0;
         end else begin
            while (k < tbl[i].edge_n) begin cyc(); k++; end
            check("table_phase", {22'd0, phase, dut_lamps}, {22'd0, tbl[i].ph, lamps_for(tbl[i].ph)});
            sensor = tbl[i].s;
            walk_button = tbl[i].w;
            cyc();
            k++;
            sensor = 1'b0;
            walk_button = 1'b0;
         end
      end

      // sensor held: one extension (4 ticks of side green), then served again
      do_reset();
      sensor = 1'b1;
      sg = 0;
      for (int i = 1; i <= 52; i++) begin
         cyc();
         if (i <= 40 && side_green) sg++;
         if (i == 48) check("held_main_y", {29'd0, phase}, {29'd0, 3'd1});
         if (i == 52) check("held_reserve", {29'd0, phase}, {29'd0, 3'd2});
      end
      check("ext_len", sg, 16);
      sensor = 1'b0;

      // async reset in the middle of WALK drops the pending walk
      do_reset();
      cyc();
      sensor = 1'b1;
      walk_button = 1'b1;
      cyc();
      sensor = 1'b0;
      walk_button = 1'b0;
      n = 0;
      while (phase != 3'd4 && n < 100) begin cyc(); n++; end
      check("reach_walk", {29'd0, phase}, {29'd0, 3'd4});
      cyc();
      do_reset();
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         cyc();
         if (phase != 3'd0) bad++;
      end
      check("walk_req_lost", bad, 0);

`ifdef PREEMPT_EN
      do_reset();
      cyc();
      sensor = 1'b1;
      cyc();
      sensor = 1'b0;
      for (int i = 3; i <= 17; i++) cyc();
      check("pre_side_g", {29'd0, phase}, {29'd0, 3'd2});
      preempt = 1'b1;
      walk_button = 1'b1;
      cyc();
      walk_button = 1'b0;
      check("pre_side_y", {28'd0, side_yellow, phase}, {28'd0, 1'b1, 3'd3});
      bad = 0;
      for (int i = 19; i <= 40; i++) begin
         cyc();
         if (i >= 20 && phase != 3'd0) bad++;
      end
      check("pre_hold_main", bad, 0);
      preempt = 1'b0;
      n = 0;
      while (phase != 3'd4 && n < 100) begin cyc(); n++; end
      check("pre_walk_served", {28'd0, walk_light, phase}, {28'd0, 1'b1, 3'd4});
`endif

      // randomized requests against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         sensor = ($urandom_range(0, 5) == 0);
         walk_button = ($urandom_range(0, 9) == 0);
`ifdef PREEMPT_EN
         if ($urandom_range(0, 49) == 0) preempt = ~preempt;
`endif
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
